// File: rtl/vga_mem_arbiter_pkg.sv
// vga_mem_arbiter_pkg
//   Shared definitions for the framebuffer SRAM arbiter.
//   - Grant encoding: who owns the SRAM port in the current cycle.
//   - Default address width and posted-write queue depth.
//   - Free-slot helper used by the grant logic.
package vga_mem_arbiter_pkg;

  localparam int AW_DEFAULT       = 21;
  localparam int WQ_DEPTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    GNT_VID = 2'd0,
    GNT_WR  = 2'd1,
    GNT_RD  = 2'd2
  } gnt_e;

  // A cycle is free for the CPU during the vga idle pulse or anywhere in vsync.
  function automatic logic is_free_slot(input logic vid_idle, input logic vid_vsync_n);
    return vid_idle | ~vid_vsync_n;
  endfunction

endpackage

// File: rtl/vga_mem_arbiter_wq_fifo.sv
// vga_mem_arbiter_wq_fifo
//   Posted-write queue carrying {addr, data} for CPU writes.
//   Ports:
//     clk, resetq  clock, asynchronous active-low reset
//     push, din    enqueue din (accepted when not full, or when full and
//                  popping in the same cycle)
//     pop          dequeue head (ignored when empty)
//     full, empty  occupancy flags, derived from the pointers only
//     head         oldest entry, valid while !empty
//   Pointers carry one extra wrap bit so full and empty are distinguishable.
module vga_mem_arbiter_wq_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 29
) (
  input  logic             clk,
  input  logic             resetq,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                 (wr_ptr_q[IW-1:0] == rd_ptr_q[IW-1:0]);

  // A pop in the same cycle frees the slot the push lands in.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign head = mem_q[rd_ptr_q[IW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: entries are only visible between the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[IW-1:0]] <= din;
  end

endmodule

// File: rtl/vga_mem_arbiter.sv
// vga_mem_arbiter
//   Shares the single 8-bit framebuffer SRAM port between vga scan-out and
//   the CPU bus. Video owns the port except in free slots (vid_idle high or
//   vid_vsync_n low). In a free slot, queued CPU writes drain first, then a
//   pending CPU read is serviced; otherwise the video address is driven.
//   Ports:
//     clk, resetq                     clock, asynchronous active-low reset
//     vid_addr, vid_idle, vid_vsync_n vga fetch address and slot markers
//     vid_rd                          pass-through of mem_rdata to vga
//     cpu_valid/we/addr/wdata         CPU request
//     cpu_ready                       request accepted this cycle
//     cpu_rvalid, cpu_rdata           read completion pulse and held data
//     mem_addr/wdata/we_n/oe_n        SRAM pads
//     mem_rdata                       SRAM read data (same-cycle)
//   CPU handshake: a request transfers on a cycle with cpu_valid & cpu_ready;
//   the CPU holds cpu_valid/we/addr/wdata stable while cpu_ready is low.
//   cpu_ready is combinational from cpu_valid/cpu_we and internal state.
module vga_mem_arbiter
  import vga_mem_arbiter_pkg::*;
#(
  parameter int AW       = AW_DEFAULT,
  parameter int WQ_DEPTH = WQ_DEPTH_DEFAULT
) (
  input  logic          clk,
  input  logic          resetq,
  input  logic [AW-1:0] vid_addr,
  input  logic          vid_idle,
  input  logic          vid_vsync_n,
  output logic [7:0]    vid_rd,
  input  logic          cpu_valid,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_wdata,
  output logic          cpu_ready,
  output logic          cpu_rvalid,
  output logic [7:0]    cpu_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  output logic          mem_we_n,
  output logic          mem_oe_n,
  input  logic [7:0]    mem_rdata
);

  localparam int QW = AW + 8;

  logic          slot;
  gnt_e          gnt;
  logic          wq_full;
  logic          wq_empty;
  logic          wq_push;
  logic          wq_pop;
  logic [QW-1:0] wq_head;
  logic          wr_acc;
  logic          rd_acc;

  logic          rd_pend_q, rd_pend_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic          rvalid_q,  rvalid_d;
  logic [7:0]    rdata_q,   rdata_d;

  assign vid_rd = mem_rdata;
  assign slot   = is_free_slot(vid_idle, vid_vsync_n);

  // Writes are refused while a read is outstanding so the read cannot be
  // overtaken in the other direction either; the queue only ever holds
  // writes older than any pending read. Nothing is accepted in reset,
  // since the queue and tracker would drop it.
  assign wr_acc    = resetq & cpu_valid &  cpu_we & ~wq_full & ~rd_pend_q;
  assign rd_acc    = resetq & cpu_valid & ~cpu_we & ~rd_pend_q;
  assign cpu_ready = wr_acc | rd_acc;

  assign wq_push = wr_acc;
  assign wq_pop  = (gnt == GNT_WR);

  vga_mem_arbiter_wq_fifo #(
    .DEPTH (WQ_DEPTH),
    .WIDTH (QW)
  ) u_wq (
    .clk    (clk),
    .resetq (resetq),
    .push   (wq_push),
    .pop    (wq_pop),
    .din    ({cpu_addr, cpu_wdata}),
    .full   (wq_full),
    .empty  (wq_empty),
    .head   (wq_head)
  );

  // Grant: write drain beats the pending read so reads see earlier writes.
  always_comb begin
    gnt = GNT_VID;
    if (slot && !wq_empty)     gnt = GNT_WR;
    else if (slot && rd_pend_q) gnt = GNT_RD;
  end

  // Port mux. The queue head is always presented on mem_wdata; it only
  // matters while mem_we_n is low.
  always_comb begin
    mem_addr  = vid_addr;
    mem_wdata = wq_head[7:0];
    mem_we_n  = 1'b1;
    mem_oe_n  = 1'b0;
    case (gnt)
      GNT_WR: begin
        mem_addr = wq_head[QW-1:8];
        mem_we_n = 1'b0;
        mem_oe_n = 1'b1;
      end
      GNT_RD: begin
        mem_addr = rd_addr_q;
      end
      default: begin
        mem_addr = vid_addr;
      end
    endcase
  end

  // Read tracker: accept and completion never coincide because a read is
  // only accepted while nothing is pending.
  always_comb begin
    rd_pend_d = rd_pend_q;
    rd_addr_d = rd_addr_q;
    rvalid_d  = 1'b0;
    rdata_d   = rdata_q;
    if (rd_acc) begin
      rd_pend_d = 1'b1;
      rd_addr_d = cpu_addr;
    end
    if (gnt == GNT_RD) begin
      rd_pend_d = 1'b0;
      rdata_d   = mem_rdata;
      rvalid_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      rd_pend_q <= 1'b0;
      rd_addr_q <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= 8'h00;
    end else begin
      rd_pend_q <= rd_pend_d;
      rd_addr_q <= rd_addr_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
    end
  end

  assign cpu_rvalid = rvalid_q;
  assign cpu_rdata  = rdata_q;

endmodule

// File: tb/tb_vga_mem_arbiter.sv
module tb_vga_mem_arbiter;

  localparam int AW = 21;
  localparam logic [1:0] TV = 2'd0;
  localparam logic [1:0] TW = 2'd1;
  localparam logic [1:0] TR = 2'd2;

  // ---------------- clock / reset / DUT ----------------
  logic          clk;
  logic          resetq;
  logic [AW-1:0] vid_addr;
  logic          vid_idle;
  logic          vid_vsync_n;
  logic [7:0]    vid_rd;
  logic          cpu_valid;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_wdata;
  logic          cpu_ready;
  logic          cpu_rvalid;
  logic [7:0]    cpu_rdata;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          mem_we_n;
  logic          mem_oe_n;
  logic [7:0]    mem_rdata;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  vga_mem_arbiter #(.AW(AW), .WQ_DEPTH(4)) dut (
    .clk         (clk),
    .resetq      (resetq),
    .vid_addr    (vid_addr),
    .vid_idle    (vid_idle),
    .vid_vsync_n (vid_vsync_n),
    .vid_rd      (vid_rd),
    .cpu_valid   (cpu_valid),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_ready   (cpu_ready),
    .cpu_rvalid  (cpu_rvalid),
    .cpu_rdata   (cpu_rdata),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_we_n    (mem_we_n),
    .mem_oe_n    (mem_oe_n),
    .mem_rdata   (mem_rdata)
  );

  // ---------------- SRAM model (low address byte only) ----------------
  logic [7:0] sram [256];
  assign mem_rdata = sram[mem_addr[7:0]];
  always @(posedge clk) begin
    if (!mem_we_n) sram[mem_addr[7:0]] <= mem_wdata;
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic          rst;
    logic [AW-1:0] vaddr;
    logic          idle;
    logic          vs_n;
    logic          cv;
    logic          cwe;
    logic [AW-1:0] caddr;
    logic [7:0]    cwd;
    logic          e_rdy;
    logic [1:0]    e_gnt;
    logic [AW-1:0] e_addr;
    logic [7:0]    e_wd;
    logic          e_rv;
    logic          chk_rd;
    logic [7:0]    e_rd;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic rst, idle, vs_n, cv, cwe,
                              input logic [AW-1:0] caddr, input logic [7:0] cwd,
                              input logic e_rdy, input logic [1:0] e_gnt,
                              input logic [AW-1:0] e_addr, input logic [7:0] e_wd,
                              input logic e_rv, input logic chk_rd, input logic [7:0] e_rd);
    vec_t v;
    v.rst = rst; v.idle = idle; v.vs_n = vs_n; v.cv = cv; v.cwe = cwe;
    v.vaddr = 21'h0A000 + AW'(vecs.size());
    v.caddr = caddr; v.cwd = cwd; v.e_rdy = e_rdy; v.e_gnt = e_gnt;
    v.e_addr = e_addr; v.e_wd = e_wd; v.e_rv = e_rv; v.chk_rd = chk_rd; v.e_rd = e_rd;
    vecs.push_back(v);
  endfunction

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int row, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (row %0d): got %h expected %h", name, row, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input vec_t v);
    resetq      = v.rst;
    vid_addr    = v.vaddr;
    vid_idle    = v.idle;
    vid_vsync_n = v.vs_n;
    cpu_valid   = v.cv;
    cpu_we      = v.cwe;
    cpu_addr    = v.caddr;
    cpu_wdata   = v.cwd;
  endtask

  task automatic check_row(input int i, input vec_t v);
    logic [AW-1:0] ea;
    ea = (v.e_gnt == TV) ? v.vaddr : v.e_addr;
    chk("cpu_ready",  i, 32'(cpu_ready),  32'(v.e_rdy));
    chk("mem_we_n",   i, 32'(mem_we_n),   32'(v.e_gnt != TW));
    chk("mem_oe_n",   i, 32'(mem_oe_n),   32'(v.e_gnt == TW));
    chk("mem_addr",   i, 32'(mem_addr),   32'(ea));
    chk("cpu_rvalid", i, 32'(cpu_rvalid), 32'(v.e_rv));
    chk("vid_rd",     i, 32'(vid_rd),     32'(sram[ea[7:0]]));
    if (v.e_gnt == TW) chk("mem_wdata", i, 32'(mem_wdata), 32'(v.e_wd));
    if (v.chk_rd)      chk("cpu_rdata", i, 32'(cpu_rdata), 32'(v.e_rd));
  endtask

  // ---------------- test ----------------
  initial begin
    for (int k = 0; k < 256; k++) sram[k] = 8'h00;

    // Reset with a request on the bus, then release into an empty idle slot.
    add(0,1'b0,1,1,1,21'h00100,8'h11, 0,TV,0,0, 0,1,8'h00);
    add(0,1'b1,1,1,1,21'h00100,8'h11, 0,TV,0,0, 0,1,8'h00);
    add(1,1'b1,1,0,0,0,0,             0,TV,0,0, 0,1,8'h00);
    // Posted write in active video, drained in the next idle pulse.
    add(1,0,1,1,1,21'h00100,8'h5A,    1,TV,0,0, 0,0,0);
    add(1,0,1,0,0,0,0,                0,TV,0,0, 0,0,0);
    add(1,0,1,0,0,0,0,                0,TV,0,0, 0,0,0);
    add(1,0,1,0,0,0,0,                0,TV,0,0, 0,0,0);
    add(1,1,1,0,0,0,0,                0,TW,21'h00100,8'h5A, 0,0,0);
    add(1,0,1,0,0,0,0,                0,TV,0,0, 0,0,0);
    add(1,1,1,0,0,0,0,                0,TV,0,0, 0,0,0);
    // Fill the queue with no free slot; 5th write held until the first pop.
    for (int k = 0; k < 4; k++)
      add(1,0,1,1,1,21'h00201 + AW'(k),8'(k+1), 1,TV,0,0, 0,0,0);
    add(1,0,1,1,1,21'h00205,8'h05,    0,TV,0,0, 0,0,0);
    add(1,0,1,1,1,21'h00205,8'h05,    0,TV,0,0, 0,0,0);
    add(1,1,1,1,1,21'h00205,8'h05,    0,TW,21'h00201,8'h01, 0,0,0);
    add(1,0,1,1,1,21'h00205,8'h05,    1,TV,0,0, 0,0,0);
    add(1,0,1,0,0,0,0,                0,TV,0,0, 0,0,0);
    for (int k = 0; k < 4; k++)
      add(1,1,1,0,0,0,0,              0,TW,21'h00202 + AW'(k),8'(k+2), 0,0,0);
    add(1,1,1,0,0,0,0,                0,TV,0,0, 0,0,0);
    // Read after write; a write arriving while the read is pending is held.
    add(1,0,1,1,1,21'h1F000,8'hC3,    1,TV,0,0, 0,0,0);
    add(1,0,1,1,0,21'h1F000,8'h00,    1,TV,0,0, 0,0,0);
    add(1,0,1,1,1,21'h00300,8'h77,    0,TV,0,0, 0,0,0);
    add(1,1,1,1,1,21'h00300,8'h77,    0,TW,21'h1F000,8'hC3, 0,0,0);
    add(1,1,1,1,1,21'h00300,8'h77,    0,TR,21'h1F000,0, 0,0,0);
    add(1,0,1,1,1,21'h00300,8'h77,    1,TV,0,0, 1,1,8'hC3);
    add(1,0,1,0,0,0,0,                0,TV,0,0, 0,1,8'hC3);
    add(1,1,1,0,0,0,0,                0,TW,21'h00300,8'h77, 0,1,8'hC3);
    // Vblank burst: consecutive writes, read granted right after the last.
    add(1,0,0,1,1,21'h00410,8'hA1,    1,TV,0,0, 0,0,0);
    add(1,0,0,1,1,21'h00411,8'hA2,    1,TW,21'h00410,8'hA1, 0,0,0);
    add(1,0,0,1,1,21'h00412,8'hA3,    1,TW,21'h00411,8'hA2, 0,0,0);
    add(1,0,0,1,0,21'h00411,8'h00,    1,TW,21'h00412,8'hA3, 0,0,0);
    add(1,0,0,0,0,0,0,                0,TR,21'h00411,0, 0,0,0);
    add(1,0,0,0,0,0,0,                0,TV,0,0, 1,1,8'hA2);
    add(1,0,0,0,0,0,0,                0,TV,0,0, 0,1,8'hA2);
    // Reset while a read is pending, then a fresh read.
    add(1,0,1,1,0,21'h00412,8'h00,    1,TV,0,0, 0,0,0);
    add(1,0,1,0,0,0,0,                0,TV,0,0, 0,0,0);
    add(0,1,1,0,0,0,0,                0,TV,0,0, 0,1,8'h00);
    add(1,1,1,0,0,0,0,                0,TV,0,0, 0,1,8'h00);
    add(1,0,1,0,0,0,0,                0,TV,0,0, 0,1,8'h00);
    add(1,0,1,1,0,21'h00412,8'h00,    1,TV,0,0, 0,0,0);
    add(1,1,1,0,0,0,0,                0,TR,21'h00412,0, 0,0,0);
    add(1,0,1,0,0,0,0,                0,TV,0,0, 1,1,8'hA3);
    add(1,0,1,0,0,0,0,                0,TV,0,0, 0,1,8'hA3);
    // Reset with a queued write: it is discarded.
    add(1,0,1,1,1,21'h00500,8'h99,    1,TV,0,0, 0,0,0);
    add(0,1,1,0,0,0,0,                0,TV,0,0, 0,0,0);
    add(1,1,1,0,0,0,0,                0,TV,0,0, 0,0,0);

    // Hold reset across one edge before the table starts.
    drive(vecs[0]);
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      #3;
      check_row(i, vecs[i]);
      @(posedge clk); #1;
    end

    // Hand-written: read during vblank, bounded wait for a single rvalid pulse.
    begin
      bit seen;
      int hs = 1000;
      seen = 1'b0;
      resetq = 1'b1; vid_idle = 1'b0; vid_vsync_n = 1'b0;
      cpu_valid = 1'b1; cpu_we = 1'b0; cpu_addr = 21'h00410; cpu_wdata = 8'h00;
      #3;
      chk("hs_ready", hs, 32'(cpu_ready), 32'd1);
      @(posedge clk); #1;
      cpu_valid = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
        #3;
        if (cpu_rvalid) seen = 1'b1;
        else begin
          @(posedge clk); #1;
        end
      end
      chk("hs_rvalid_seen", hs, 32'(seen), 32'd1);
      chk("hs_rdata", hs, 32'(cpu_rdata), 32'h000000A1);
      @(posedge clk); #1; #3;
      chk("hs_rvalid_single", hs, 32'(cpu_rvalid), 32'd0);
      chk("hs_rdata_held", hs, 32'(cpu_rdata), 32'h000000A1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_mem_arbiter.md
Name: vga_mem_arbiter

Overview:
- Shares the single 8-bit framebuffer SRAM port between the vga scan-out fetcher and the CPU bus.
- Video always owns the port, except in free slots. A free slot is the one-cycle vga idle pulse per 5-cycle pixel period, or any cycle while vsync is asserted.
- CPU writes are posted through a small FIFO. CPU reads are single-outstanding and blocking.
- Sits between vga, the CPU I/O decoder and the SRAM pads.

Parameters:
- AW, 21, address width (matches the vga addr port).
- WQ_DEPTH, 4, posted-write FIFO depth (power of two, 2..16).

Ports:
- clk  in  1  main clock
- resetq  in  1  asynchronous active-low reset
- vid_addr  in  AW  vga fetch address
- vid_idle  in  1  vga idle pulse; high marks a free slot
- vid_vsync_n  in  1  vga vsync; low marks a free slot every cycle
- vid_rd  out  8  read data to vga; always equals mem_rdata (pass-through)
- cpu_valid  in  1  CPU request strobe
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  8  CPU write data
- cpu_ready  out  1  request accepted this cycle (combinational)
- cpu_rvalid  out  1  one-cycle pulse; cpu_rdata valid
- cpu_rdata  out  8  read result, held until the next read completes
- mem_addr  out  AW  SRAM address
- mem_wdata  out  8  SRAM write data
- mem_we_n  out  1  SRAM write enable, active low
- mem_oe_n  out  1  SRAM output enable, active low
- mem_rdata  in  8  SRAM read data, valid in the same cycle as mem_addr

Behaviour:
- Clock and reset: all state uses one clock (clk). Reset is asynchronous and active-low (resetq).
- Reset values:
  - FIFO empty, rd_pend=0, cpu_rvalid=0, cpu_rdata=0.
  - Outputs follow the idle mux: mem_we_n=1, mem_oe_n=0.
- Free slot: slot = vid_idle | !vid_vsync_n, evaluated combinationally each cycle.
- Grant per cycle (combinational mux), in priority order:
  1. slot & FIFO non-empty -> write grant:
     - mem_addr/mem_wdata = FIFO head, mem_we_n=0, mem_oe_n=1.
     - FIFO pops at the clock edge.
  2. slot & FIFO empty & rd_pend -> read grant:
     - mem_addr = rd_addr, mem_we_n=1, mem_oe_n=0.
     - At the edge: cpu_rdata <= mem_rdata, rd_pend <= 0, and cpu_rvalid pulses high the following cycle.
  3. Otherwise -> video:
     - mem_addr = vid_addr, mem_we_n=1, mem_oe_n=0.
- Ordering: writes drain before any read. A read never overtakes an earlier posted write (read-after-write coherent).
- Accept rules:
  - Write: cpu_ready = cpu_valid & cpu_we & !full & !rd_pend.
  - Read: cpu_ready = cpu_valid & !cpu_we & !rd_pend. An accepted read latches rd_addr and sets rd_pend.
  - A CPU request is held while cpu_ready=0.
- Read latency: from acceptance to cpu_rvalid = wait for FIFO drain + next slot + 1 cycle.
  - With FIFO empty and vsync low: accept at cycle N, grant at N+1, cpu_rvalid at N+2.
- Simultaneous push and pop in one cycle are allowed when the FIFO is full: a pop frees the entry pushed the same edge. Count is unchanged and no data is lost. The full flag is computed before the pop, so cpu_ready stays 0 in that case (conservative).
- FIFO pointers are log2(WQ_DEPTH)+1 bits and wrap modulo 2*WQ_DEPTH.
  - full = (ptr MSBs differ & lower bits equal).
  - empty = (ptrs equal).
- cpu_rvalid is exactly one cycle per accepted read, never back-to-back with the same read.
- Reset mid-operation: pending FIFO entries and the outstanding read are discarded, and no rvalid is issued. The SRAM write strobe deasserts immediately (asynchronous).
- The video path is never stalled. The vga fetcher tolerates garbage on vid_rd during free slots by construction.

Decomposition:
- Shared package: grant encoding constants (GNT_VID=0, GNT_WR=1, GNT_RD=2) and the AW default.
- One sub-module: wq_fifo, a synchronous FIFO carrying {addr, data}.
  - Ports: push, pop, full, empty, head.
  - Async active-low reset, parameterised depth and width.
- Slot/grant logic and the read tracker stay in the top.

Test Plan:
- Reset:
  - Stimulus: assert resetq=0 with cpu_valid=1.
  - Required: mem_we_n=1, cpu_rvalid=0, FIFO empty, mem_addr=vid_addr.
  - After release, the first idle pulse with nothing queued produces no write.
- Posted write in active video:
  - Stimulus: vid_vsync_n=1, vid_idle pulsing every 5 cycles; write 0x5A to 0x00100.
  - Required: cpu_ready=1 the same cycle; mem_we_n=0 with mem_addr=0x00100 only in the next vid_idle=1 cycle; mem_addr=vid_addr in all other cycles.
- FIFO full:
  - Stimulus: push 5 writes back-to-back with no free slot (vid_idle=0, vsync_n=1).
  - Required: first 4 accepted; the 5th is held with cpu_ready=0 until the first pop; entries drain in order over 4 subsequent slots.
- Read after write:
  - Stimulus: write 0xC3 to 0x1F000, then immediately read 0x1F000 with a memory model.
  - Required: write slot precedes read slot; cpu_rvalid pulses once with cpu_rdata=0xC3.
- Vblank burst:
  - Stimulus: vid_vsync_n=0; queue 3 writes then a read.
  - Required: writes issued on consecutive cycles; read granted the cycle after the last write; cpu_rvalid 1 cycle later.
- Reset mid-read:
  - Stimulus: assert resetq while rd_pend=1.
  - Required: no cpu_rvalid afterwards; a new read after release completes normally.
